cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Run sequencer and data-memory port arbiter for the single-cycle CPU core. Holds the core in reset while the host loads or inspects data memory. On `req` it resets the core for a fixed number of cycles, releases it, and waits for the core's `done` or a cycle-count timeout. It then reports completion and the run length back to the host. It sits between the host/testbench and `top_level`, and owns the `dat_mem` port mux.

## Interface

Parameters:
- `AW`, 8, data-memory address width
- `DW`, 8, data-memory data width
- `RST_CYC`, 2, cycles the core reset is held after a start (≥1)
- `TIMEOUT`, 4096, maximum RUN cycles before forced stop (≥2, ≤65535)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  1  host start request (level)
- `done`  out  1  run finished; held until `req` low
- `busy`  out  1  high in RESET or RUN
- `timeout`  out  1  valid with `done`: run ended by timeout
- `cycles`  out  16  RUN cycles of last/current run, saturating
- `cpu_reset`  out  1  active-high reset to core
- `cpu_done`  in  1  core completion flag
- `cpu_mem_wr_en`  in  1  core store enable
- `cpu_mem_addr`  in  AW  core memory address
- `cpu_mem_wdata`  in  DW  core store data
- `host_gnt`  out  1  host owns memory port this cycle
- `host_wr_en`  in  1  host store enable
- `host_addr`  in  AW  host memory address
- `host_wdata`  in  DW  host store data
- `mem_wr_en`  out  1  to `dat_mem.wr_en`
- `mem_addr`  out  AW  to `dat_mem.addr`
- `mem_wdata`  out  DW  to `dat_mem.dat_in`

## Operation

- Four states: IDLE, RESET, RUN, DONE. Use binary encoding.
- IDLE:
  - `req`=1 → RESET.
  - Clear `cycles` and `timeout`, and load the reset counter with RST_CYC-1 on that edge.
- RESET:
  - Decrement the reset counter.
  - At 0 → RUN.
  - `cpu_done` is ignored.
- RUN:
  - `cycles` increments every cycle and saturates at 16'hFFFF.
  - `cpu_done`=1 → DONE with `timeout`=0.
  - If `cpu_done`=0 and `cycles`==TIMEOUT-1, the state goes to DONE with `timeout`=1. On that same edge `cycles` increments to TIMEOUT.
  - If `cpu_done` and the timeout condition occur in the same cycle, `cpu_done` wins (`timeout`=0).
  - `req` is ignored.
- DONE:
  - `done`=1.
  - `cycles` and `timeout` hold.
  - `req`=0 → IDLE.
  - `req` held high does not restart the core; one run per `req` pulse.
- Outputs by state:
  - `cpu_reset` = 1 in every state except RUN.
  - `busy` = RESET or RUN.
  - `host_gnt` = IDLE or DONE.
- Memory mux (combinational):
  - `host_gnt`=1: `mem_*` = `host_*`.
  - RUN: `mem_*` = `cpu_*`.
  - RESET: `mem_wr_en`=0, address/data = cpu inputs.
  - Host writes while `host_gnt`=0 are dropped, not queued.
- Asynchronous reset (`reset`=0), at any time including mid-run:
  - State goes to IDLE.
  - `done`=0, `busy`=0, `timeout`=0, `cycles`=0.
  - `cpu_reset`=1, `host_gnt`=1.

## Timing

- `done`, `busy`, `timeout`, `cycles`, `cpu_reset` and `host_gnt` are registered or decoded directly from state. No combinational path runs from inputs to these outputs.
- `mem_*` is the only combinational input-to-output path.
- Start latency: with `req` sampled high at edge 0, `cpu_reset` is high for cycles 1..RST_CYC. The core's first RUN cycle is RST_CYC+1.
- Completion latency: `cpu_done` sampled high at edge N puts DONE (`done`=1) in effect after edge N. `cycles` then equals the number of RUN cycles, counting the `cpu_done` cycle.
- Release: `req` sampled low in DONE gives IDLE and `done`=0 on the next cycle. A new start needs `req` sampled high again in IDLE, which takes at least 1 cycle low.
- Reset deassertion is synchronised by the integrator. The block requires `reset` release to meet `clk` recovery/removal timing.

## Test plan

- Reset defaults: pulse `reset`=0 mid-RUN (`cycles`=37). Required: immediately `busy`=0, `cycles`=0, `cpu_reset`=1, `host_gnt`=1. No further counting after release.
- Normal run, RST_CYC=2: `req`=1 at edge 0, `cpu_done` raised at the 10th RUN cycle. Required:
  - `cpu_reset` high cycles 1–2, low from cycle 3.
  - `done`=1, `cycles`=10, `timeout`=0.
  - `done` stays high until `req` drops, then IDLE.
- Timeout, TIMEOUT=16: start with `cpu_done` tied 0. Required: DONE after 16 RUN cycles, `timeout`=1, `cycles`=16, `cpu_reset`=1 again.
- Simultaneous: `cpu_done`=1 exactly on RUN cycle TIMEOUT. Required: `timeout`=0, `cycles`=TIMEOUT.
- Arbitration:
  - Host writes 8'hA5 to address 8'h10 in IDLE → `mem_wr_en`=1, `mem_addr`=8'h10.
  - Host write during RUN → `mem_*` follows the `cpu_*` inputs, host write absent.
  - During RESET, `mem_wr_en`=0 even with `cpu_mem_wr_en`=1.
- Held `req`: `req` kept high through DONE for 20 cycles. Required: no restart, `busy` stays 0. A low-then-high `req` starts a second run with `cycles` cleared.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//   Run sequencer and data-memory port arbiter for the single-cycle CPU core.
//   The core is held in reset while the host owns data memory. A start request
//   resets the core for RST_CYC cycles, lets it run until it signals completion
//   or the run reaches TIMEOUT cycles, then reports completion and run length.
//
// Ports
//   clk, reset            system clock, asynchronous active-low reset
//   req                   host start request (level; one run per high period)
//   done, busy, timeout   run status (registered or decoded from state)
//   cycles[15:0]          RUN cycles of the last/current run, saturating
//   cpu_reset             active-high reset to the core
//   cpu_done              core completion flag
//   cpu_mem_*             core-side data-memory request
//   host_gnt              host owns the memory port this cycle
//   host_*                host-side data-memory request
//   mem_*                 muxed data-memory port (combinational)
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int RST_CYC = 2,
   parameter int TIMEOUT = 4096
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   output logic          done,
   output logic          busy,
   output logic          timeout,
   output logic [15:0]   cycles,
   output logic          cpu_reset,
   input  logic          cpu_done,
   input  logic          cpu_mem_wr_en,
   input  logic [AW-1:0] cpu_mem_addr,
   input  logic [DW-1:0] cpu_mem_wdata,
   output logic          host_gnt,
   input  logic          host_wr_en,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata
);

   // Counter only needs to hold RST_CYC-1; keep at least one bit for RST_CYC=1.
   localparam int              RCW      = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [RCW-1:0]  RST_LOAD = RCW'(RST_CYC - 1);
   localparam logic [15:0]     TO_LAST  = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RESET = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
   logic [15:0]      cycles_q, cycles_d;
   logic             timeout_q, timeout_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         rst_cnt_q <= '0;
         cycles_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         cycles_q  <= cycles_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      cycles_d  = cycles_q;
      timeout_d = timeout_q;
      case (state_q)
         ST_IDLE: begin
            // Status of the previous run stays visible until the next start.
            if (req) begin
               state_d   = ST_RESET;
               rst_cnt_d = RST_LOAD;
               cycles_d  = '0;
               timeout_d = 1'b0;
            end
         end
         ST_RESET: begin
            if (rst_cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               rst_cnt_d = rst_cnt_q - RCW'(1);
            end
         end
         ST_RUN: begin
            if (cycles_q != 16'hFFFF) begin
               cycles_d = cycles_q + 16'd1;
            end
            // cpu_done takes priority over a timeout in the same cycle.
            if (cpu_done) begin
               state_d   = ST_DONE;
               timeout_d = 1'b0;
            end else if (cycles_q == TO_LAST) begin
               state_d   = ST_DONE;
               timeout_d = 1'b1;
            end
         end
         ST_DONE: begin
            // Require req low before returning to IDLE: one run per pulse.
            if (!req) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign done      = (state_q == ST_DONE);
   assign busy      = (state_q == ST_RESET) || (state_q == ST_RUN);
   assign cpu_reset = (state_q != ST_RUN);
   assign host_gnt  = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign timeout   = timeout_q;
   assign cycles    = cycles_q;

   // Host requests outside host_gnt are simply dropped. In RESET the core's
   // outputs are not trustworthy, so its store enable is suppressed.
   always_comb begin
      mem_wr_en = 1'b0;
      mem_addr  = cpu_mem_addr;
      mem_wdata = cpu_mem_wdata;
      if (host_gnt) begin
         mem_wr_en = host_wr_en;
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
      end else if (state_q == ST_RUN) begin
         mem_wr_en = cpu_mem_wr_en;
      end
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

   localparam int AW      = 8;
   localparam int DW      = 8;
   localparam int RST_CYC = 2;
   localparam int TIMEOUT = 40;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          req = 1'b0;
   logic          done, busy, timeout, cpu_reset, host_gnt;
   logic [15:0]   cycles;
   logic          cpu_done = 1'b0;
   logic          cpu_mem_wr_en = 1'b0;
   logic [AW-1:0] cpu_mem_addr = '0;
   logic [DW-1:0] cpu_mem_wdata = '0;
   logic          host_wr_en = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] host_wdata = '0;
   logic          mem_wr_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   cpu_run_ctrl #(.AW(AW), .DW(DW), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req(req),
      .done(done), .busy(busy), .timeout(timeout), .cycles(cycles),
      .cpu_reset(cpu_reset), .cpu_done(cpu_done),
      .cpu_mem_wr_en(cpu_mem_wr_en), .cpu_mem_addr(cpu_mem_addr),
      .cpu_mem_wdata(cpu_mem_wdata),
      .host_gnt(host_gnt), .host_wr_en(host_wr_en), .host_addr(host_addr),
      .host_wdata(host_wdata),
      .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: a run is described by the edge at which it was
   // accepted; RESET/RUN phases and the run length follow from elapsed time.
   bit m_busy = 0, m_fin = 0, m_to = 0;
   int m_s = 0, m_cyc = 0, ecount = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy <= 0; m_fin <= 0; m_cyc <= 0; m_to <= 0;
      end else begin
         ecount <= ecount + 1;
         if (m_fin) begin
            if (!req) m_fin <= 0;
         end else if (!m_busy) begin
            if (req) begin
               m_busy <= 1; m_s <= ecount; m_cyc <= 0; m_to <= 0;
            end
         end else if (ecount - m_s > RST_CYC) begin
            m_cyc <= (ecount - m_s - RST_CYC > 65535) ? 65535 : ecount - m_s - RST_CYC;
            if (cpu_done) begin
               m_busy <= 0; m_fin <= 1; m_to <= 0;
            end else if (ecount - m_s - RST_CYC == TIMEOUT) begin
               m_busy <= 0; m_fin <= 1; m_to <= 1;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en && reset) begin
         bit m_run, m_gnt;
         int e_wr, e_addr, e_wd;
         m_run = m_busy && (ecount - m_s > RST_CYC);
         m_gnt = !m_busy;
         e_wr   = m_gnt ? int'(host_wr_en) : (m_run ? int'(cpu_mem_wr_en) : 0);
         e_addr = m_gnt ? int'(host_addr)  : int'(cpu_mem_addr);
         e_wd   = m_gnt ? int'(host_wdata) : int'(cpu_mem_wdata);
         chk("m_done",      int'(done),      int'(m_fin));
         chk("m_busy",      int'(busy),      int'(m_busy));
         chk("m_timeout",   int'(timeout),   int'(m_to));
         chk("m_cycles",    int'(cycles),    m_cyc);
         chk("m_cpu_reset", int'(cpu_reset), int'(!m_run));
         chk("m_host_gnt",  int'(host_gnt),  int'(m_gnt));
         chk("m_mem_wr_en", int'(mem_wr_en), e_wr);
         chk("m_mem_addr",  int'(mem_addr),  e_addr);
         chk("m_mem_wdata", int'(mem_wdata), e_wd);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   // Starts a run from IDLE; returns in RUN cycle 1.
   task automatic start_run();
      req = 1'b1;
      repeat (RST_CYC + 1) tick();
   endtask

   task automatic release_req();
      req = 1'b0;
      tick();
   endtask

   initial begin
      repeat (3) tick();
      reset = 1'b1;
      chk_en = 1'b1;
      tick();
      at_neg();
      chk("reset_cpu_reset", int'(cpu_reset), 1);
      chk("reset_host_gnt",  int'(host_gnt),  1);
      chk("reset_cycles",    int'(cycles),    0);
      $display("txn reset_defaults done");

      // Normal run: cpu_done in RUN cycle 10.
      tick();
      req = 1'b1;
      tick();  at_neg(); chk("norm_rst_c1", int'(cpu_reset), 1);
      tick();  at_neg(); chk("norm_rst_c2", int'(cpu_reset), 1);
      tick();  at_neg(); chk("norm_rst_c3", int'(cpu_reset), 0);
      repeat (9) tick();
      cpu_done = 1'b1;
      tick();
      cpu_done = 1'b0;
      at_neg();
      chk("norm_done",    int'(done),    1);
      chk("norm_cycles",  int'(cycles),  10);
      chk("norm_timeout", int'(timeout), 0);
      repeat (3) tick();
      at_neg(); chk("norm_done_hold", int'(done), 1);
      release_req();
      at_neg(); chk("norm_release", int'(done), 0);
      $display("txn normal_run cycles=%0d", cycles);

      // Timeout run.
      tick();
      start_run();
      repeat (TIMEOUT - 1) tick();
      tick();
      at_neg();
      chk("to_done",      int'(done),      1);
      chk("to_timeout",   int'(timeout),   1);
      chk("to_cycles",    int'(cycles),    TIMEOUT);
      chk("to_cpu_reset", int'(cpu_reset), 1);
      release_req();
      $display("txn timeout_run cycles=%0d", cycles);

      // cpu_done on the timeout cycle.
      tick();
      start_run();
      repeat (TIMEOUT - 1) tick();
      cpu_done = 1'b1;
      tick();
      cpu_done = 1'b0;
      at_neg();
      chk("sim_timeout", int'(timeout), 0);
      chk("sim_cycles",  int'(cycles),  TIMEOUT);
      release_req();
      $display("txn simultaneous cycles=%0d", cycles);

      // Arbitration.
      tick();
      host_wr_en = 1'b1; host_addr = 8'h10; host_wdata = 8'hA5;
      at_neg();
      chk("arb_idle_wr",   int'(mem_wr_en), 1);
      chk("arb_idle_addr", int'(mem_addr),  8'h10);
      chk("arb_idle_data", int'(mem_wdata), 8'hA5);
      tick();
      req = 1'b1;
      tick();
      cpu_mem_wr_en = 1'b1; cpu_mem_addr = 8'h33; cpu_mem_wdata = 8'h5C;
      at_neg();
      chk("arb_reset_wr", int'(mem_wr_en), 0);
      repeat (RST_CYC) tick();
      cpu_mem_wr_en = 1'b0; host_addr = 8'h44;
      at_neg();
      chk("arb_run_wr",   int'(mem_wr_en), 0);
      chk("arb_run_addr", int'(mem_addr),  8'h33);
      host_wr_en = 1'b0;
      cpu_done = 1'b1;
      tick();
      cpu_done = 1'b0;
      release_req();
      $display("txn arbitration done");

      // Asynchronous reset mid-run at cycles=37.
      tick();
      start_run();
      repeat (37) tick();
      at_neg();
      chk("mid_cycles_pre", int'(cycles), 37);
      #1 reset = 1'b0; req = 1'b0;
      #1;
      chk("mid_busy",      int'(busy),      0);
      chk("mid_cycles",    int'(cycles),    0);
      chk("mid_cpu_reset", int'(cpu_reset), 1);
      chk("mid_host_gnt",  int'(host_gnt),  1);
      #1 reset = 1'b1;
      repeat (5) tick();
      at_neg();
      chk("mid_no_count", int'(cycles), 0);
      $display("txn mid_run_reset done");

      // Held req through DONE.
      tick();
      start_run();
      cpu_done = 1'b1;
      tick();
      cpu_done = 1'b0;
      repeat (20) tick();
      at_neg();
      chk("held_busy", int'(busy), 0);
      chk("held_done", int'(done), 1);
      release_req();
      req = 1'b1;
      tick();
      at_neg();
      chk("held_restart_busy",   int'(busy),   1);
      chk("held_restart_cycles", int'(cycles), 0);
      $display("txn held_req done");
      repeat (RST_CYC + 3) tick();
      cpu_done = 1'b1;
      tick();
      cpu_done = 1'b0;

      // Randomized phase.
      for (int i = 0; i < 3000; i++) begin
         tick();
         if ($urandom_range(0, 7) == 0) req = ~req;
         cpu_done      = ($urandom_range(0, 39) == 0);
         cpu_mem_wr_en = 1'($urandom);
         cpu_mem_addr  = 8'($urandom);
         cpu_mem_wdata = 8'($urandom);
         host_wr_en    = 1'($urandom);
         host_addr     = 8'($urandom);
         host_wdata    = 8'($urandom);
         if ($urandom_range(0, 499) == 0) begin
            #2 reset = 1'b0;
            #1 reset = 1'b1;
            $display("txn random async_reset at iter %0d", i);
         end
      end
      tick();
      at_neg();
      $display("txn random phase done");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
